// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the 5-stage core datapath.
// The core drives the master side; the controller sits on the slave side.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd_addr;
   logic             ex_mem_read;
   logic             ex_valid;
   logic             ex_redirect;
   logic             ex_mc_req;
   logic             mc_done;
   logic             mem_busy;
   logic             cnt_clr;
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_flush;
   logic             exmem_bubble;
   logic             mc_start;
   logic             mc_abort;
   logic             mc_timeout;
   logic             protocol_err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
             ex_mem_read, ex_valid, ex_redirect, ex_mc_req, mc_done, mem_busy, cnt_clr,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble,
             mc_start, mc_abort, mc_timeout, protocol_err, stall_cnt
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
             ex_mem_read, ex_valid, ex_redirect, ex_mc_req, mc_done, mem_busy, cnt_clr,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble,
             mc_start, mc_abort, mc_timeout, protocol_err, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use interlock, EX redirect flush,
// memory freeze, and a start/done/timeout FSM for the multi-cycle EX unit.
module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int TW = $clog2(MC_TIMEOUT);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      MC_HOLD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             mc_block_q, mc_block_d;
   logic             mc_timeout_q, mc_timeout_d;
   logic             protocol_err_q, protocol_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic mc_issue;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic exmem_bubble, mc_start, mc_abort;

   assign load_use = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd_addr != 5'd0) &
                     ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                      (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

   // An aborted op leaves its instruction in EX; mc_block_q keeps it from re-issuing.
   assign mc_issue = hz.ex_valid & hz.ex_mc_req & ~mc_block_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d        = state_q;
      timer_d        = timer_q;
      mc_block_d     = mc_block_q;
      mc_timeout_d   = mc_timeout_q;
      protocol_err_d = protocol_err_q;
      pc_stall       = 1'b0;
      ifid_stall     = 1'b0;
      ifid_flush     = 1'b0;
      idex_stall     = 1'b0;
      idex_flush     = 1'b0;
      exmem_bubble   = 1'b0;
      mc_start       = 1'b0;
      mc_abort       = 1'b0;

      unique case (state_q)
         RUN: begin
            if (hz.mc_done) protocol_err_d = 1'b1;
            // Without mem_busy the EX instruction always moves on this cycle.
            if (!hz.mem_busy) mc_block_d = 1'b0;
            if (hz.mem_busy) begin
               {pc_stall, ifid_stall, idex_stall} = 3'b111;
            end else if (mc_issue) begin
               {pc_stall, ifid_stall, idex_stall} = 3'b111;
               exmem_bubble = 1'b1;
               mc_start     = 1'b1;
               state_d      = MC_WAIT;
               timer_d      = '0;
               if (hz.ex_redirect) protocol_err_d = 1'b1;
            end else if (hz.ex_redirect) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end
         end

         MC_WAIT: begin
            {pc_stall, ifid_stall, idex_stall} = 3'b111;
            exmem_bubble = 1'b1;
            timer_d      = timer_q + TW'(1);
            if (hz.ex_redirect) protocol_err_d = 1'b1;
            if (hz.mc_done) begin
               if (!hz.mem_busy) begin
                  {pc_stall, ifid_stall, idex_stall} = 3'b000;
                  exmem_bubble = 1'b0;
                  state_d      = RUN;
               end else begin
                  state_d = MC_HOLD;
               end
            end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
               mc_abort     = 1'b1;
               mc_timeout_d = 1'b1;
               mc_block_d   = 1'b1;
               state_d      = RUN;
            end
         end

         MC_HOLD: begin
            {pc_stall, ifid_stall, idex_stall} = {3{hz.mem_busy}};
            if (!hz.mem_busy) state_d = RUN;
         end

         default: state_d = RUN;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (hz.cnt_clr)                            stall_cnt_d = '0;
      else if (pc_stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= RUN;
         timer_q        <= '0;
         mc_block_q     <= 1'b0;
         mc_timeout_q   <= 1'b0;
         protocol_err_q <= 1'b0;
         stall_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         mc_block_q     <= mc_block_d;
         mc_timeout_q   <= mc_timeout_d;
         protocol_err_q <= protocol_err_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign hz.pc_stall     = pc_stall;
   assign hz.ifid_stall   = ifid_stall;
   assign hz.ifid_flush   = ifid_flush;
   assign hz.idex_stall   = idex_stall;
   assign hz.idex_flush   = idex_flush;
   assign hz.exmem_bubble = exmem_bubble;
   assign hz.mc_start     = mc_start;
   assign hz.mc_abort     = mc_abort;
   assign hz.mc_timeout   = mc_timeout_q;
   assign hz.protocol_err = protocol_err_q;
   assign hz.stall_cnt    = stall_cnt_q;
endmodule
